// File: rtl/fpga_instruction_arb_pkg.sv
// Shared types and sizing constants for the Neo-chip instruction link arbiter.
package fpga_instruction_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACKD = 3'd2,
    REL  = 3'd3,
    NEXT = 3'd4
  } arb_state_t;

  localparam int INSTR_W    = 147;
  localparam int CHUNK_W    = 32;
  localparam int CHUNKS_DEF = (INSTR_W + CHUNK_W - 1) / CHUNK_W;

endpackage

// File: rtl/fpga_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping.
module fpga_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // The pointer itself is searched last, so the previous owner has lowest priority.
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(rr_ptr) + k) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fpga_instruction_arbiter.sv
// Round-robin arbiter sharing the 4-phase instruction link to the Neo chip,
// granting one whole instruction per owner, with a per-handshake stall watchdog.
module fpga_instruction_arbiter
  import fpga_instruction_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = CHUNK_W,
  parameter int CHUNKS  = CHUNKS_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          src_req,
  input  logic [NUM_REQ*DATA_W-1:0]   src_chunk,
  output logic [NUM_REQ-1:0]          src_ack,
  output logic                        link_req,
  output logic [DATA_W-1:0]           link_chunk,
  input  logic                        link_ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0]  RR_RESET   = ID_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   chunk_cnt_q, chunk_cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  link_chunk_q, link_chunk_d;
  logic               link_req_q, link_req_d;
  logic [NUM_REQ-1:0] src_ack_q, src_ack_d;
  logic               timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               busy_q, busy_d;

  logic               pick_valid_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               wd_expired_s;
  logic               timeout_set_s;

  fpga_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req    (src_req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  assign wd_expired_s = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    chunk_cnt_d   = chunk_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    link_chunk_d  = link_chunk_q;
    link_req_d    = link_req_q;
    src_ack_d     = src_ack_q;
    timeout_set_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          grant_id_d   = pick_idx_s;
          link_chunk_d = src_chunk[int'(pick_idx_s) * DATA_W +: DATA_W];
          link_req_d   = 1'b1;
          state_d      = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A source dropping its request here is a protocol violation and is ignored.
        if (link_ack) begin
          src_ack_d[grant_id_q] = 1'b1;
          state_d               = ACKD;
        end else if (wd_expired_s) begin
          timeout_set_s = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      ACKD: begin
        if (!src_req[grant_id_q]) begin
          link_req_d = 1'b0;
          state_d    = REL;
        end else begin
          state_d = ACKD;
        end
      end
      REL: begin
        if (!link_ack) begin
          src_ack_d = '0;
          if (chunk_cnt_q == LAST_CHUNK) begin
            chunk_cnt_d = '0;
            rr_ptr_d    = grant_id_q;
            state_d     = IDLE;
          end else begin
            chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
            state_d     = NEXT;
          end
        end else if (wd_expired_s) begin
          timeout_set_s = 1'b1;
        end else begin
          state_d = REL;
        end
      end
      NEXT: begin
        // Only the owner may continue; other sources wait for IDLE.
        if (src_req[grant_id_q]) begin
          link_chunk_d = src_chunk[int'(grant_id_q) * DATA_W +: DATA_W];
          link_req_d   = 1'b1;
          state_d      = REQ;
        end else begin
          state_d = NEXT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abandon the stalled instruction and demote its source.
    if (timeout_set_s) begin
      link_req_d  = 1'b0;
      src_ack_d   = '0;
      chunk_cnt_d = '0;
      rr_ptr_d    = grant_id_q;
      state_d     = IDLE;
    end else begin
      state_d = state_d;
    end

    if (timeout_set_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end

    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (state_q == REQ || state_q == REL) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      chunk_cnt_q   <= '0;
      rr_ptr_q      <= RR_RESET;
      grant_id_q    <= '0;
      link_chunk_q  <= '0;
      link_req_q    <= 1'b0;
      src_ack_q     <= '0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      chunk_cnt_q   <= chunk_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      link_chunk_q  <= link_chunk_d;
      link_req_q    <= link_req_d;
      src_ack_q     <= src_ack_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign src_ack     = src_ack_q;
  assign link_req    = link_req_q;
  assign link_chunk  = link_chunk_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule
